// File: rtl/regfile_writeback_pkg.sv
// Shared widths and queue entry layout for the register-file write-back slice.
package regfile_writeback_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int NUM_REGISTER = 32;
    localparam int AW           = $clog2(NUM_REGISTER);

    typedef struct packed {
        logic                  valid;
        logic [AW-1:0]         addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Producer, register-file write port and decode bypass signals of the write-back unit.
interface regfile_writeback_if;
    import regfile_writeback_pkg::*;

    logic                    i_lsu_valid;
    logic                    o_lsu_ready;
    logic [AW-1:0]           i_lsu_rd_addr;
    logic [DATA_WIDTH-1:0]   i_lsu_data;

    logic                    i_alu_valid;
    logic                    o_alu_ready;
    logic [AW-1:0]           i_alu_rd_addr;
    logic [DATA_WIDTH-1:0]   i_alu_data;

    logic                    o_we;
    logic [AW-1:0]           o_rd_addr;
    logic [DATA_WIDTH-1:0]   o_rd;

    logic [AW-1:0]           i_rs1_addr;
    logic [AW-1:0]           i_rs2_addr;
    logic                    o_rs1_fwd;
    logic                    o_rs2_fwd;
    logic [DATA_WIDTH-1:0]   o_rs1_fwd_data;
    logic [DATA_WIDTH-1:0]   o_rs2_fwd_data;

    logic [NUM_REGISTER-1:0] o_busy;
    logic                    o_empty;

    modport master (
        output i_lsu_valid, i_lsu_rd_addr, i_lsu_data,
        output i_alu_valid, i_alu_rd_addr, i_alu_data,
        output i_rs1_addr, i_rs2_addr,
        input  o_lsu_ready, o_alu_ready,
        input  o_we, o_rd_addr, o_rd,
        input  o_rs1_fwd, o_rs2_fwd, o_rs1_fwd_data, o_rs2_fwd_data,
        input  o_busy, o_empty
    );

    modport slave (
        input  i_lsu_valid, i_lsu_rd_addr, i_lsu_data,
        input  i_alu_valid, i_alu_rd_addr, i_alu_data,
        input  i_rs1_addr, i_rs2_addr,
        output o_lsu_ready, o_alu_ready,
        output o_we, o_rd_addr, o_rd,
        output o_rs1_fwd, o_rs2_fwd, o_rs1_fwd_data, o_rs2_fwd_data,
        output o_busy, o_empty
    );

endinterface

// File: rtl/regfile_wb_queue.sv
// Circular in-order result queue: two ordered push ports (a older than b), one pop,
// and per-entry address compare returning the youngest matching entry's data.
module regfile_wb_queue
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_push_a,
    input  logic [AW-1:0]                 i_a_addr,
    input  logic [DATA_WIDTH-1:0]         i_a_data,
    input  logic                          i_push_b,
    input  logic [AW-1:0]                 i_b_addr,
    input  logic [DATA_WIDTH-1:0]         i_b_data,
    output wb_entry_t                     o_head,
    output logic [$clog2(DEPTH+1)-1:0]    o_count,
    output logic [DEPTH-1:0]              o_valid,
    output logic [DEPTH-1:0][AW-1:0]      o_addr,
    input  logic [AW-1:0]                 i_rs1_addr,
    input  logic [AW-1:0]                 i_rs2_addr,
    output logic                          o_rs1_hit,
    output logic [DATA_WIDTH-1:0]         o_rs1_data,
    output logic                          o_rs2_hit,
    output logic [DATA_WIDTH-1:0]         o_rs2_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    wb_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  pop;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         idx;

    // The register file always accepts, so any resident head retires every cycle.
    assign pop = (count_q != '0);

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        wr_ptr    = tail_q;
        if (pop) begin
            entries_d[head_q].valid = 1'b0;
            head_d = head_q + 1'b1;
        end
        if (i_push_a) begin
            entries_d[wr_ptr] = '{valid: 1'b1, addr: i_a_addr, data: i_a_data};
            wr_ptr = wr_ptr + 1'b1;
        end
        if (i_push_b) begin
            entries_d[wr_ptr] = '{valid: 1'b1, addr: i_b_addr, data: i_b_data};
            wr_ptr = wr_ptr + 1'b1;
        end
        tail_d  = wr_ptr;
        count_d = count_q + CW'(i_push_a) + CW'(i_push_b) - CW'(pop);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        o_rs1_hit  = 1'b0;
        o_rs1_data = '0;
        o_rs2_hit  = 1'b0;
        o_rs2_data = '0;
        idx        = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (entries_q[idx].valid && entries_q[idx].addr == i_rs1_addr) begin
                o_rs1_hit  = 1'b1;
                o_rs1_data = entries_q[idx].data;
            end
            if (entries_q[idx].valid && entries_q[idx].addr == i_rs2_addr) begin
                o_rs2_hit  = 1'b1;
                o_rs2_data = entries_q[idx].data;
            end
        end
    end

    always_comb begin
        o_valid = '0;
        o_addr  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_valid[i] = entries_q[i].valid;
            o_addr[i]  = entries_q[i].addr;
        end
    end

    assign o_head  = entries_q[head_q];
    assign o_count = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// Write-back unit: merges LSU and ALU results into one register-file write port,
// with a pending-write scoreboard and youngest-data bypass for decode.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    regfile_writeback_if.slave  bus
);

    localparam int            CW     = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] ALMOST = CW'(DEPTH-1);

    logic [CW-1:0]           count;
    logic                    lsu_ready;
    logic                    alu_ready;
    logic                    push_lsu;
    logic                    push_alu;
    wb_entry_t               head;
    logic [DEPTH-1:0]        ent_valid;
    logic [DEPTH-1:0][AW-1:0] ent_addr;
    logic                    rs1_hit;
    logic                    rs2_hit;
    logic [DATA_WIDTH-1:0]   rs1_data;
    logic [DATA_WIDTH-1:0]   rs2_data;
    logic [NUM_REGISTER-1:0] busy;

    // Readies look only at registered occupancy; the ALU yields the last slot to the LSU.
    always_comb begin
        lsu_ready = (count < FULL);
        alu_ready = (count < ALMOST) || (count == ALMOST && !bus.i_lsu_valid);
        push_lsu  = bus.i_lsu_valid && lsu_ready && (bus.i_lsu_rd_addr != '0);
        push_alu  = bus.i_alu_valid && alu_ready && (bus.i_alu_rd_addr != '0);
    end

    regfile_wb_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push_a   (push_lsu),
        .i_a_addr   (bus.i_lsu_rd_addr),
        .i_a_data   (bus.i_lsu_data),
        .i_push_b   (push_alu),
        .i_b_addr   (bus.i_alu_rd_addr),
        .i_b_data   (bus.i_alu_data),
        .o_head     (head),
        .o_count    (count),
        .o_valid    (ent_valid),
        .o_addr     (ent_addr),
        .i_rs1_addr (bus.i_rs1_addr),
        .i_rs2_addr (bus.i_rs2_addr),
        .o_rs1_hit  (rs1_hit),
        .o_rs1_data (rs1_data),
        .o_rs2_hit  (rs2_hit),
        .o_rs2_data (rs2_data)
    );

    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                busy[ent_addr[i]] = 1'b1;
            end
        end
        busy[0] = 1'b0;
    end

    assign bus.o_lsu_ready    = lsu_ready;
    assign bus.o_alu_ready    = alu_ready;
    assign bus.o_we           = head.valid;
    assign bus.o_rd_addr      = head.valid ? head.addr : '0;
    assign bus.o_rd           = head.valid ? head.data : '0;
    assign bus.o_rs1_fwd      = rs1_hit && (bus.i_rs1_addr != '0);
    assign bus.o_rs2_fwd      = rs2_hit && (bus.i_rs2_addr != '0);
    assign bus.o_rs1_fwd_data = (rs1_hit && bus.i_rs1_addr != '0) ? rs1_data : '0;
    assign bus.o_rs2_fwd_data = (rs2_hit && bus.i_rs2_addr != '0) ? rs2_data : '0;
    assign bus.o_busy         = busy;
    assign bus.o_empty        = (count == '0);

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized self-checking bench for regfile_writeback against a queue-based reference model.
module tb_regfile_writeback;
    import regfile_writeback_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        logic [AW-1:0]         addr;
        logic [DATA_WIDTH-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic                  s_lsu_valid;
    logic [AW-1:0]         s_lsu_addr;
    logic [DATA_WIDTH-1:0] s_lsu_data;
    logic                  s_alu_valid;
    logic [AW-1:0]         s_alu_addr;
    logic [DATA_WIDTH-1:0] s_alu_data;

    ent_t                  model_q[$];
    logic [DATA_WIDTH-1:0] model_rf [NUM_REGISTER] = '{default: '0};
    logic [DATA_WIDTH-1:0] tb_rf    [NUM_REGISTER] = '{default: '0};

    bit lf, af;

    regfile_writeback_if bus ();

    regfile_writeback #(
        .DEPTH (DEPTH)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Register file the unit drives; deliberately not reset so dropped writes show up.
    always @(posedge clk) begin
        if (bus.o_we) tb_rf[bus.o_rd_addr] <= bus.o_rd;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic lv, input logic [AW-1:0] la, input logic [DATA_WIDTH-1:0] ld,
                                 input logic av, input logic [AW-1:0] aa, input logic [DATA_WIDTH-1:0] ad,
                                 input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        s_lsu_valid = lv; s_lsu_addr = la; s_lsu_data = ld;
        s_alu_valid = av; s_alu_addr = aa; s_alu_data = ad;
        bus.i_lsu_valid   = lv;
        bus.i_lsu_rd_addr = la;
        bus.i_lsu_data    = ld;
        bus.i_alu_valid   = av;
        bus.i_alu_rd_addr = aa;
        bus.i_alu_data    = ad;
        bus.i_rs1_addr    = r1;
        bus.i_rs2_addr    = r2;
    endtask

    function automatic void model_fwd(input logic [AW-1:0] a, output logic hit, output logic [DATA_WIDTH-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != 0) begin
            foreach (model_q[k]) begin
                if (model_q[k].addr == a) begin
                    hit = 1'b1;
                    d   = model_q[k].data;
                end
            end
        end
    endfunction

    task automatic check_all();
        int                      cnt;
        logic [NUM_REGISTER-1:0] exp_busy;
        logic                    h1, h2;
        logic [DATA_WIDTH-1:0]   d1, d2;
        cnt      = model_q.size();
        exp_busy = '0;
        foreach (model_q[k]) exp_busy[model_q[k].addr] = 1'b1;
        model_fwd(bus.i_rs1_addr, h1, d1);
        model_fwd(bus.i_rs2_addr, h2, d2);
        checkOutput("lsu_ready", bus.o_lsu_ready, cnt < DEPTH);
        checkOutput("alu_ready", bus.o_alu_ready,
                    (cnt < DEPTH-1) || (cnt == DEPTH-1 && !s_lsu_valid));
        checkOutput("we",      bus.o_we,      cnt != 0);
        checkOutput("rd_addr", bus.o_rd_addr, (cnt != 0) ? model_q[0].addr : '0);
        checkOutput("rd_data", bus.o_rd,      (cnt != 0) ? model_q[0].data : '0);
        checkOutput("empty",   bus.o_empty,   cnt == 0);
        checkOutput("busy",    bus.o_busy,    exp_busy);
        checkOutput("rs1_fwd",  bus.o_rs1_fwd,      h1);
        checkOutput("rs1_data", bus.o_rs1_fwd_data, d1);
        checkOutput("rs2_fwd",  bus.o_rs2_fwd,      h2);
        checkOutput("rs2_data", bus.o_rs2_fwd_data, d2);
        checkOutput("rf_rs1",   tb_rf[bus.i_rs1_addr], model_rf[bus.i_rs1_addr]);
    endtask

    // Check this cycle, then advance the model across the next rising edge.
    task automatic run_cycle(output bit lsu_fire, output bit alu_fire);
        int   cnt;
        ent_t e;
        #1;
        check_all();
        cnt      = model_q.size();
        lsu_fire = s_lsu_valid && (cnt < DEPTH);
        alu_fire = s_alu_valid && ((cnt < DEPTH-1) || (cnt == DEPTH-1 && !s_lsu_valid));
        @(posedge clk);
        if (cnt != 0) begin
            e = model_q.pop_front();
            model_rf[e.addr] = e.data;
        end
        if (lsu_fire && s_lsu_addr != 0) model_q.push_back('{addr: s_lsu_addr, data: s_lsu_data});
        if (alu_fire && s_alu_addr != 0) model_q.push_back('{addr: s_alu_addr, data: s_alu_data});
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        applyStimulus(0, '0, '0, 0, '0, '0, r1, r2);
        for (int i = 0; i < n; i++) run_cycle(lf, af);
    endtask

    initial begin
        bit                    lsu_pend, alu_pend;
        logic                  lv, av;
        logic [AW-1:0]         la, aa;
        logic [DATA_WIDTH-1:0] ld, ad;

        rst_n = 1'b0;
        applyStimulus(0, '0, '0, 0, '0, '0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        @(negedge clk);

        // Single ALU write to x5, visible via bypass first, register file next
        applyStimulus(0, '0, '0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        run_cycle(lf, af);
        idle(1, 5'd5, 5'd0);
        checkOutput("x5_in_rf", tb_rf[5], 32'hDEADBEEF);
        idle(1, 5'd5, 5'd0);

        // Dual write to the same destination: LSU older, ALU youngest
        applyStimulus(1, 5'd7, 32'h11, 1, 5'd7, 32'h22, 5'd7, 5'd7);
        run_cycle(lf, af);
        checkOutput("dual_lsu_fire", lf, 1'b1);
        checkOutput("dual_alu_fire", af, 1'b1);
        applyStimulus(1, 5'd9, 32'h33, 1, 5'd10, 32'h44, 5'd7, 5'd9);
        for (int i = 0; i < 6; i++) run_cycle(lf, af);
        idle(3, 5'd7, 5'd10);
        checkOutput("x7_last", tb_rf[7], 32'h22);

        // Write to x0 handshakes but never reaches the register file
        applyStimulus(0, '0, '0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        run_cycle(lf, af);
        checkOutput("x0_alu_fire", af, 1'b1);
        idle(2, 5'd0, 5'd0);
        checkOutput("x0_rf", tb_rf[0], 32'h0);

        // Back-to-back ALU stream x1..x8
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, '0, '0, 1, AW'(i), 32'h1000_0000 + i, AW'(i), AW'(i-1));
            run_cycle(lf, af);
            checkOutput("stream_fire", af, 1'b1);
        end
        idle(2, 5'd8, 5'd3);

        // Reset while x3/x4 are still queued drops both writes
        applyStimulus(1, 5'd3, 32'hAAAA_0003, 1, 5'd4, 32'hAAAA_0004, 5'd3, 5'd4);
        run_cycle(lf, af);
        applyStimulus(0, '0, '0, 0, '0, '0, 5'd3, 5'd4);
        rst_n = 1'b0;
        #1;
        model_q.delete();
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 5'd4, 5'd3);
        checkOutput("x3_kept", tb_rf[3], 32'h1000_0003);
        checkOutput("x4_kept", tb_rf[4], 32'h1000_0004);

        // Randomized traffic; a producer holds its payload until accepted
        lsu_pend = 0; alu_pend = 0;
        lv = 0; la = '0; ld = '0; av = 0; aa = '0; ad = '0;
        for (int n = 0; n < 1500; n++) begin
            if (!lsu_pend) begin
                lv = ($urandom_range(0, 3) != 0);
                la = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, NUM_REGISTER-1))
                                                 : AW'($urandom_range(0, 7));
                ld = $urandom;
            end
            if (!alu_pend) begin
                av = ($urandom_range(0, 3) != 0);
                aa = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, NUM_REGISTER-1))
                                                 : AW'($urandom_range(0, 7));
                ad = $urandom;
            end
            applyStimulus(lv, la, ld, av, aa, ad,
                          AW'($urandom_range(0, 9)), AW'($urandom_range(0, 9)));
            run_cycle(lf, af);
            lsu_pend = lv && !lf;
            alu_pend = av && !af;
        end

        idle(DEPTH + 2, 5'd1, 5'd2);
        for (int r = 0; r < NUM_REGISTER; r++) begin
            checkOutput($sformatf("rf_final_x%0d", r), tb_rf[r], model_rf[r]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
